// File: rtl/flits_sender_pkg.sv
// Shared NIC transmit definitions: flit geometry, flit-type codes and a helper
// that stamps the type field into a flit.
package flits_sender_pkg;

    localparam int unsigned FLIT_WIDTH        = 16;
    localparam int unsigned MAX_PACKET_LENGHT = 7;
    localparam int unsigned N_BITS_FLIT_TYPE  = 2;

    // The type field occupies the most significant bits of every flit.
    localparam int unsigned FLIT_TYPE_HI = FLIT_WIDTH - 1;
    localparam int unsigned FLIT_TYPE_LO = FLIT_WIDTH - N_BITS_FLIT_TYPE;

    typedef logic [FLIT_WIDTH-1:0] flit_t;

    typedef enum logic [N_BITS_FLIT_TYPE-1:0] {
        BODY_FLIT      = 2'b00,
        TAIL_FLIT      = 2'b01,
        HEAD_FLIT      = 2'b10,
        HEAD_TAIL_FLIT = 2'b11
    } flit_type_e;

    function automatic flit_t set_flit_type(input flit_t f, input flit_type_e t);
        flit_t r;
        r = f;
        r[FLIT_TYPE_HI:FLIT_TYPE_LO] = t;
        return r;
    endfunction

endpackage

// File: rtl/flits_sender_credit_counter.sv
// Saturating credit counter for credit-based link flow control; starts full,
// decrements on use and increments on each returned credit.
module credit_counter #(
    parameter int unsigned N_CREDITS     = 4,
    parameter int unsigned N_BITS_CREDIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     dec,
    output logic [N_BITS_CREDIT-1:0] count,
    output logic                     zero
);

    localparam logic [N_BITS_CREDIT-1:0] MAX_COUNT = N_BITS_CREDIT'(N_CREDITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= MAX_COUNT;
        end else begin
            // inc and dec together cancel out; excess returned credit is dropped
            unique case ({inc, dec})
                2'b10: if (count != MAX_COUNT) count <= count + N_BITS_CREDIT'(1);
                2'b01: if (count != '0)        count <= count - N_BITS_CREDIT'(1);
                default: count <= count;
            endcase
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/flits_sender.sv
// NIC transmit stage: accepts a whole packet and serialises it flit by flit
// toward the router, gated by link credits and downstream buffer allocation.
module flits_sender
    import flits_sender_pkg::*;
#(
    parameter int unsigned N_BITS_POINTER = 3,
    parameter int unsigned N_CREDITS      = 4,
    parameter int unsigned N_BITS_CREDIT  = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  r_msg_to_pkt_i,
    output logic                                  g_msg_to_pkt_o,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
    input  logic [N_BITS_POINTER-1:0]             in_n_flits_i,
    output logic [FLIT_WIDTH-1:0]                 out_link_o,
    output logic                                  is_valid_o,
    input  logic                                  credit_signal_i,
    input  logic                                  free_signal_i
);

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        SENDING   = 3'b010,
        WAIT_FREE = 3'b100
    } state_t;

    state_t                    state, state_next;
    flit_t                     packet_r [MAX_PACKET_LENGHT];
    logic [N_BITS_POINTER-1:0] len_r;
    logic [N_BITS_POINTER-1:0] idx;
    logic                      ds_busy;
    logic                      grant;
    logic                      send;
    logic                      is_head;
    logic                      is_last;
    logic                      credits_zero;
    logic [N_BITS_CREDIT-1:0]  credits;
    flit_type_e                cur_type;

    credit_counter #(
        .N_CREDITS    (N_CREDITS),
        .N_BITS_CREDIT(N_BITS_CREDIT)
    ) u_credits (
        .clk  (clk),
        .rst  (rst),
        .inc  (credit_signal_i),
        .dec  (send),
        .count(credits),
        .zero (credits_zero)
    );

    assign is_head = (idx == '0);
    assign is_last = (idx == len_r - N_BITS_POINTER'(1));

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        send       = 1'b0;
        unique case (state)
            IDLE: begin
                grant = r_msg_to_pkt_i;
                if (r_msg_to_pkt_i) state_next = ds_busy ? WAIT_FREE : SENDING;
            end
            WAIT_FREE: begin
                // A free arriving now clears ds_busy at this edge, so move on without waiting a cycle
                if (!ds_busy || free_signal_i) state_next = SENDING;
            end
            SENDING: begin
                send = !credits_zero && !(is_head && ds_busy);
                if (send && is_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cur_type = BODY_FLIT;
        if (len_r == N_BITS_POINTER'(1)) cur_type = HEAD_TAIL_FLIT;
        else if (is_head)                cur_type = HEAD_FLIT;
        else if (is_last)                cur_type = TAIL_FLIT;
    end

    assign g_msg_to_pkt_o = grant;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            for (int unsigned i = 0; i < MAX_PACKET_LENGHT; i++) begin
                packet_r[i] <= in_link_i[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_r      <= N_BITS_POINTER'(1);
            idx        <= '0;
            ds_busy    <= 1'b0;
            is_valid_o <= 1'b0;
            out_link_o <= '0;
        end else begin
            is_valid_o <= send;
            if (grant) begin
                len_r <= (in_n_flits_i == '0) ? N_BITS_POINTER'(1) : in_n_flits_i;
                idx   <= '0;
            end
            if (send) begin
                out_link_o <= set_flit_type(packet_r[idx], cur_type);
                idx        <= idx + N_BITS_POINTER'(1);
            end
            // A free seen while sending a head belongs to the previous packet
            if (send && is_head)    ds_busy <= 1'b1;
            else if (free_signal_i) ds_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flits_sender.sv
// Scoreboard bench for flits_sender: stimulus queues expected flits, a monitor
// checks every valid flit; timing, credits and state are checked inline.
module tb_flits_sender;

    localparam int FW = 16;
    localparam int ML = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              grant;
    logic [ML*FW-1:0]  in_link;
    logic [2:0]        n_flits;
    logic [FW-1:0]     out_link;
    logic              is_valid;
    logic              credit;
    logic              free;
    logic [2:0]        st;
    logic [2:0]        cr;

    logic [FW-1:0]     exp_q [$];
    int                tests = 0;
    int                fails = 0;

    always #5 clk = ~clk;

    flits_sender #(
        .N_BITS_POINTER(3),
        .N_CREDITS     (4),
        .N_BITS_CREDIT (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .r_msg_to_pkt_i (req),
        .g_msg_to_pkt_o (grant),
        .in_link_i      (in_link),
        .in_n_flits_i   (n_flits),
        .out_link_o     (out_link),
        .is_valid_o     (is_valid),
        .credit_signal_i(credit),
        .free_signal_i  (free)
    );

    assign st = dut.state;
    assign cr = dut.credits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] raw_flit(input int seed, input int k);
        return {2'b01, 6'(seed), 8'(k)};
    endfunction

    // Type codes: body 00, tail 01, head 10, head+tail 11
    function automatic logic [1:0] exp_type(input int n, input int k);
        if (n == 1)     return 2'b11;
        if (k == 0)     return 2'b10;
        if (k == n - 1) return 2'b01;
        return 2'b00;
    endfunction

    // Presents a packet while the DUT is idle; returns one cycle later with req low.
    task automatic request(input int n, input int seed);
        logic [FW-1:0] r;
        in_link = '0;
        for (int k = 0; k < n; k++) begin
            r = raw_flit(seed, k);
            in_link[k*FW +: FW] = r;
            exp_q.push_back({exp_type(n, k), r[FW-3:0]});
        end
        n_flits = 3'(n);
        req     = 1'b1;
        #1;
        check("grant", {31'd0, grant}, 32'd1);
        tick();
        req = 1'b0;
    endtask

    initial begin : monitor
        logic [FW-1:0] e;
        forever begin
            @(negedge clk);
            if (is_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_flit: got %h expected no flit at %0t", out_link, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (out_link !== e) begin
                        fails++;
                        $display("FAIL flit: got %h expected %h at %0t", out_link, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; credit = 1'b0; free = 1'b0;
        in_link = '0; n_flits = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, is_valid}, 32'd0);
        check("rst_link", {16'd0, out_link}, 32'd0);
        check("rst_credits", {29'd0, cr}, 32'd4);
        check("rst_state", {29'd0, st}, 32'd1);
        check("rst_grant", {31'd0, grant}, 32'd0);

        // single-flit packet
        request(1, 1);
        check("t1_valid_T1", {31'd0, is_valid}, 32'd0);
        tick();
        check("t1_valid_T2", {31'd0, is_valid}, 32'd1);
        check("t1_credits", {29'd0, cr}, 32'd3);
        tick();
        check("t1_valid_T3", {31'd0, is_valid}, 32'd0);
        check("t1_state", {29'd0, st}, 32'd1);
        credit = 1'b1; free = 1'b1;
        tick();
        credit = 1'b0; free = 1'b0;
        check("t1_refill", {29'd0, cr}, 32'd4);

        // four flits back to back, exhausting credits
        request(4, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_valid", {31'd0, is_valid}, 32'd1);
        end
        tick();
        check("t2_valid_end", {31'd0, is_valid}, 32'd0);
        check("t2_credits", {29'd0, cr}, 32'd0);
        check("t2_state", {29'd0, st}, 32'd1);
        credit = 1'b1; free = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        credit = 1'b0; free = 1'b0;
        check("t2_refill", {29'd0, cr}, 32'd4);

        // five flits with four credits: stall before the tail
        request(5, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_valid", {31'd0, is_valid}, 32'd1);
        end
        tick();
        check("t3_stall", {31'd0, is_valid}, 32'd0);
        check("t3_credits0", {29'd0, cr}, 32'd0);
        check("t3_state", {29'd0, st}, 32'd2);
        tick();
        check("t3_stall2", {31'd0, is_valid}, 32'd0);
        credit = 1'b1;
        tick();
        credit = 1'b0;
        check("t3_no_send_at_zero", {31'd0, is_valid}, 32'd0);
        check("t3_credits1", {29'd0, cr}, 32'd1);
        tick();
        check("t3_tail_valid", {31'd0, is_valid}, 32'd1);
        check("t3_credits_end", {29'd0, cr}, 32'd0);
        check("t3_state_end", {29'd0, st}, 32'd1);

        // new request while downstream still busy
        credit = 1'b1;
        tick(); tick();
        credit = 1'b0;
        check("t4_credits_pre", {29'd0, cr}, 32'd2);
        request(2, 4);
        check("t4_wait_state", {29'd0, st}, 32'd4);
        tick(); tick();
        check("t4_wait_valid", {31'd0, is_valid}, 32'd0);
        check("t4_wait_state2", {29'd0, st}, 32'd4);
        free = 1'b1;
        tick();
        free = 1'b0;
        check("t4_sending", {29'd0, st}, 32'd2);
        check("t4_valid_f1", {31'd0, is_valid}, 32'd0);
        credit = 1'b1;
        tick();
        credit = 1'b0;
        check("t4_head_valid", {31'd0, is_valid}, 32'd1);
        check("t4_credits_same", {29'd0, cr}, 32'd2);
        tick();
        check("t4_tail_valid", {31'd0, is_valid}, 32'd1);
        check("t4_credits_after", {29'd0, cr}, 32'd1);
        tick();
        check("t4_valid_end", {31'd0, is_valid}, 32'd0);
        check("t4_state_end", {29'd0, st}, 32'd1);
        credit = 1'b1; free = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        credit = 1'b0; free = 1'b0;
        check("t4_saturate", {29'd0, cr}, 32'd4);

        // reset in the middle of a packet
        request(4, 5);
        tick();
        check("t5_head_valid", {31'd0, is_valid}, 32'd1);
        tick();
        check("t5_body_valid", {31'd0, is_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t5_rst_valid", {31'd0, is_valid}, 32'd0);
        check("t5_rst_credits", {29'd0, cr}, 32'd4);
        check("t5_rst_state", {29'd0, st}, 32'd1);
        request(1, 6);
        tick();
        check("t5_new_valid", {31'd0, is_valid}, 32'd1);
        tick();
        check("t5_quiet", {31'd0, is_valid}, 32'd0);
        tick(); tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
